// File: rtl/accel_sample_sequencer.sv
// Accelerometer sampling sequencer: one setup write, then periodic X/Y/Z reads
// through an external SPI engine. Each completed set is published atomically.
module accel_sample_sequencer #(
  parameter int SAMPLE_PERIOD = 1250000,
  parameter int TIMEOUT       = 4000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       CLEAR_ERROR,
  output logic [3:0] SPI_OP,
  output logic       SPI_START,
  input  logic       SPI_BUSY,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RDATA,
  output logic [7:0] X_DATA,
  output logic [7:0] Y_DATA,
  output logic [7:0] Z_DATA,
  output logic       SAMPLE_VALID,
  output logic       READY,
  output logic       ERROR
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    SETUP_ISSUE,
    SETUP_WAIT,
    IDLE,
    ISSUE,
    WAIT_DONE,
    PUBLISH,
    FAULT
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    axis_reg, axis_next;
  logic [3:0]    op_next;
  logic [PW-1:0] period_cnt_reg;
  logic [TW-1:0] timeout_cnt_reg;
  logic          pending_reg;
  logic [7:0]    hold_reg [3];

  logic tick, timeout_hit, period_run, in_wait, next_in_wait;
  logic capture, take_pending, set_ready, fault, clear_err;

  assign period_run   = READY && ENABLE;
  assign tick         = period_run && (period_cnt_reg == PERIOD_LAST);
  assign timeout_hit  = (timeout_cnt_reg == TIMEOUT_LAST);
  assign in_wait      = (state_reg == SETUP_WAIT) || (state_reg == WAIT_DONE);
  assign next_in_wait = (state_next == SETUP_WAIT) || (state_next == WAIT_DONE);

  always_comb begin
    state_next   = state_reg;
    axis_next    = axis_reg;
    SPI_START    = 1'b0;
    capture      = 1'b0;
    take_pending = 1'b0;
    set_ready    = 1'b0;
    fault        = 1'b0;
    clear_err    = 1'b0;
    case (state_reg)
      // The op register is still 0000 on the first cycle after reset, so no
      // strobe is issued until a real command is presented.
      SETUP_ISSUE: begin
        if (!SPI_BUSY && (SPI_OP != 4'b0000)) begin
          SPI_START  = 1'b1;
          state_next = SETUP_WAIT;
        end
      end
      SETUP_WAIT: begin
        if (SPI_DONE) begin
          set_ready  = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          state_next = FAULT;
        end
      end
      IDLE: begin
        if (pending_reg) begin
          take_pending = 1'b1;
          if (ENABLE) begin
            axis_next  = 2'd0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!SPI_BUSY && (SPI_OP != 4'b0000)) begin
          SPI_START  = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (SPI_DONE) begin
          capture = 1'b1;
          if (axis_reg == 2'd2) begin
            state_next = PUBLISH;
          end else begin
            axis_next  = axis_reg + 2'd1;
            state_next = ISSUE;
          end
        end else if (timeout_hit) begin
          fault      = 1'b1;
          state_next = FAULT;
        end
      end
      PUBLISH: state_next = IDLE;
      FAULT: begin
        if (CLEAR_ERROR) begin
          clear_err  = 1'b1;
          state_next = SETUP_ISSUE;
        end
      end
      default: state_next = SETUP_ISSUE;
    endcase

    // Command follows the state being entered, so it is already valid in the
    // issue cycle and holds until DONE is accepted.
    op_next = 4'b0000;
    case (state_next)
      SETUP_ISSUE, SETUP_WAIT: op_next = 4'b1000;
      ISSUE, WAIT_DONE:        op_next = 4'b0001 << axis_next;
      default:                 op_next = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= SETUP_ISSUE;
      axis_reg        <= 2'd0;
      SPI_OP          <= 4'b0000;
      period_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      pending_reg     <= 1'b0;
      READY           <= 1'b0;
      ERROR           <= 1'b0;
      SAMPLE_VALID    <= 1'b0;
      X_DATA          <= 8'h00;
      Y_DATA          <= 8'h00;
      Z_DATA          <= 8'h00;
      for (int i = 0; i < 3; i++) hold_reg[i] <= 8'h00;
    end else begin
      state_reg <= state_next;
      axis_reg  <= axis_next;
      SPI_OP    <= op_next;

      if (!period_run || tick) period_cnt_reg <= '0;
      else                     period_cnt_reg <= period_cnt_reg + 1'b1;

      // Wait states never follow each other directly, so leaving one always
      // passes through a state that zeroes the counter.
      if (in_wait && next_in_wait) timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
      else                         timeout_cnt_reg <= '0;

      if (clear_err)                 pending_reg <= 1'b0;
      else if (tick && !pending_reg) pending_reg <= 1'b1;
      else if (take_pending)         pending_reg <= 1'b0;

      if (fault)          READY <= 1'b0;
      else if (set_ready) READY <= 1'b1;

      if (fault)          ERROR <= 1'b1;
      else if (clear_err) ERROR <= 1'b0;

      for (int i = 0; i < 3; i++) begin
        if (capture && (axis_reg == 2'(i))) hold_reg[i] <= SPI_RDATA;
      end

      SAMPLE_VALID <= (state_reg == PUBLISH);
      if (state_reg == PUBLISH) begin
        X_DATA <= hold_reg[0];
        Y_DATA <= hold_reg[1];
        Z_DATA <= hold_reg[2];
      end
    end
  end

endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Scoreboard bench for accel_sample_sequencer with a behavioural SPI engine
// (10 busy cycles then a one-cycle DONE carrying the byte for the issued axis).
module tb_accel_sample_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear_error;
  logic [3:0] spi_op;
  logic       spi_start;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rdata;
  logic [7:0] x_data, y_data, z_data;
  logic       sample_valid, ready, error;

  accel_sample_sequencer #(.SAMPLE_PERIOD(100), .TIMEOUT(50)) dut (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .CLEAR_ERROR(clear_error),
    .SPI_OP(spi_op), .SPI_START(spi_start), .SPI_BUSY(spi_busy),
    .SPI_DONE(spi_done), .SPI_RDATA(spi_rdata),
    .X_DATA(x_data), .Y_DATA(y_data), .Z_DATA(z_data),
    .SAMPLE_VALID(sample_valid), .READY(ready), .ERROR(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_valid;
    logic [3:0] op;
    logic [7:0] x, y, z;
  } ev_t;
  ev_t exp_q[$];

  logic [7:0] data_x, data_y, data_z;
  logic [3:0] withhold_op;
  logic       hold_busy;

  task automatic push_start(input logic [3:0] op);
    ev_t e;
    e.is_valid = 1'b0; e.op = op; e.x = 8'h00; e.y = 8'h00; e.z = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic push_set(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    ev_t e;
    push_start(4'b0001);
    push_start(4'b0010);
    push_start(4'b0100);
    e.is_valid = 1'b1; e.op = 4'b0000; e.x = x; e.y = y; e.z = z;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // kind 0: start with given op, 1: sample_valid, 2: ready high, 3: Z done
  task automatic wait_for(input int kind, input logic [3:0] op, input int limit, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      case (kind)
        0: seen = spi_start && (spi_op == op);
        1: seen = sample_valid;
        2: seen = ready;
        default: seen = spi_done && (spi_op == 4'b0100);
      endcase
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: event not seen within %0d cycles (required seen)", name, limit);
    end
  endtask

  // SPI engine model
  initial begin : engine
    int cnt;
    logic st;
    logic [3:0] op_l, cur_op;
    cnt = 0; cur_op = 4'b0000;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rdata = 8'h00;
    forever begin
      @(negedge clk);
      st = spi_start; op_l = spi_op;
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && cur_op != withhold_op) begin
          spi_done  = 1'b1;
          spi_rdata = (cur_op == 4'b0001) ? data_x :
                      (cur_op == 4'b0010) ? data_y :
                      (cur_op == 4'b0100) ? data_z : 8'h00;
        end
      end else if (st) begin
        cnt = 10; cur_op = op_l;
      end
      spi_busy = (cnt > 0) || hold_busy;
    end
  end

  // Monitor: every start / valid presented by the DUT is matched in order.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL start: got op=%b, expected no start", spi_op);
        end else begin
          e = exp_q.pop_front();
          if (e.is_valid || e.op !== spi_op) begin
            bad++;
            $display("FAIL start: got op=%b, expected %s op=%b", spi_op,
                     e.is_valid ? "sample_valid not start," : "start", e.op);
          end else $display("ok   start op=%b", spi_op);
        end
      end
      if (sample_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sample: got x=%h y=%h z=%h, expected no sample_valid", x_data, y_data, z_data);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_valid || {x_data, y_data, z_data} !== {e.x, e.y, e.z}) begin
            bad++;
            $display("FAIL sample: got x=%h y=%h z=%h, expected valid=%0d x=%h y=%h z=%h",
                     x_data, y_data, z_data, e.is_valid, e.x, e.y, e.z);
          end else $display("ok   sample x=%h y=%h z=%h", x_data, y_data, z_data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst = 1'b1; enable = 1'b0; clear_error = 1'b0;
    data_x = 8'h00; data_y = 8'h00; data_z = 8'h00;
    withhold_op = 4'b0000; hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset spi_op", spi_op, 4'b0000);
    check("reset outputs", {spi_start, sample_valid, ready, error}, 4'b0000);
    check("reset data", {x_data, y_data, z_data}, 24'h000000);

    // Setup with ENABLE low, then silence
    push_start(4'b1000);
    rst = 1'b0;
    @(negedge clk);
    check("op after release", spi_op, 4'b1000);
    wait_for(2, 4'b0000, 40, "ready after setup");
    n = 0;
    for (int i = 0; i < 1000; i++) begin @(negedge clk); if (spi_start) n++; end
    check("starts while disabled", n, 0);
    check("idle spi_op", spi_op, 4'b0000);

    // Periodic sampling, latency and period
    data_x = 8'h11; data_y = 8'h22; data_z = 8'h33;
    push_set(8'h11, 8'h22, 8'h33);
    push_set(8'h11, 8'h22, 8'h33);
    enable = 1'b1;
    wait_for(3, 4'b0000, 300, "z done");
    @(negedge clk);
    check("valid 1 after z done", sample_valid, 1'b0);
    @(negedge clk);
    check("valid 2 after z done", sample_valid, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); n++;
      if (sample_valid) break;
    end
    enable = 1'b0;
    check("sample interval", n, 100);

    // BUSY held across the X issue
    data_x = 8'h44; data_y = 8'h55; data_z = 8'h66;
    push_set(8'h44, 8'h55, 8'h66);
    hold_busy = 1'b1;
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 106; i++) begin @(negedge clk); if (spi_start) n++; end
    check("starts while busy", n, 0);
    hold_busy = 1'b0;
    wait_for(1, 4'b0000, 100, "valid after busy hold");
    enable = 1'b0;

    // ENABLE dropped during the Y read
    data_x = 8'h71; data_y = 8'h72; data_z = 8'h73;
    push_set(8'h71, 8'h72, 8'h73);
    enable = 1'b1;
    wait_for(0, 4'b0010, 300, "y start");
    enable = 1'b0;
    wait_for(1, 4'b0000, 100, "valid after enable drop");
    n = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (spi_start) n++; end
    check("starts after enable drop", n, 0);
    check("data after enable drop", {x_data, y_data, z_data}, 24'h717273);

    // Timeout on the Y read
    data_x = 8'h81; data_y = 8'h82; data_z = 8'h83;
    withhold_op = 4'b0010;
    push_start(4'b0001);
    push_start(4'b0010);
    enable = 1'b1;
    wait_for(0, 4'b0010, 300, "y start before timeout");
    enable = 1'b0;
    repeat (50) @(negedge clk);
    check("error at wait cycle 49", error, 1'b0);
    @(negedge clk);
    check("error at wait cycle 50", error, 1'b1);
    check("ready after fault", ready, 1'b0);
    check("fault spi_op", spi_op, 4'b0000);
    check("data after fault", {x_data, y_data, z_data}, 24'h717273);
    withhold_op = 4'b0000;
    repeat (5) @(negedge clk);
    check("error sticky", error, 1'b1);
    push_start(4'b1000);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("error cleared", error, 1'b0);
    check("re-setup op", spi_op, 4'b1000);
    wait_for(2, 4'b0000, 40, "ready after re-setup");
    check("data after re-setup", {x_data, y_data, z_data}, 24'h717273);

    // Reset during the Z wait
    data_x = 8'h91; data_y = 8'h92; data_z = 8'h93;
    push_start(4'b0001);
    push_start(4'b0010);
    push_start(4'b0100);
    enable = 1'b1;
    wait_for(0, 4'b0100, 300, "z start");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset op/start", {spi_op, spi_start}, 5'b00000);
    check("mid reset flags", {sample_valid, ready, error}, 3'b000);
    check("mid reset data", {x_data, y_data, z_data}, 24'h000000);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    push_start(4'b1000);
    rst = 1'b0;
    @(negedge clk);
    check("op after second release", spi_op, 4'b1000);
    wait_for(2, 4'b0000, 40, "ready after reset");
    n = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (sample_valid) n++; end
    check("valids after reset", n, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_sample_sequencer.md
ACCEL_SAMPLE_SEQUENCER -- requirements
Module: accel_sample_sequencer

Interface
REQ-001 The block SHALL have parameter SAMPLE_PERIOD, default 1250000, CLK cycles between sample-set starts (10 ms at 125 MHz).
REQ-002 The block SHALL have parameter TIMEOUT, default 4000000, maximum CLK cycles allowed per SPI transaction.
REQ-003 The block SHALL have port CLK  input  1  125 MHz system clock.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port ENABLE  input  1  periodic X/Y/Z sampling permitted while high.
REQ-006 The block SHALL have port CLEAR_ERROR  input  1  single-cycle request to leave the fault state.
REQ-007 The block SHALL have port SPI_OP  output  4  one-hot command to the SPI engine: 0001 X read, 0010 Y read, 0100 Z read, 1000 setup write, 0000 none.
REQ-008 The block SHALL have port SPI_START  output  1  one-cycle transaction start strobe.
REQ-009 The block SHALL have port SPI_BUSY  input  1  SPI engine transaction in progress.
REQ-010 The block SHALL have port SPI_DONE  input  1  one-cycle end-of-transaction pulse.
REQ-011 The block SHALL have port SPI_RDATA  input  8  read byte, valid only when SPI_DONE is high.
REQ-012 The block SHALL have ports X_DATA, Y_DATA, Z_DATA  output  8 each  last completed sample set.
REQ-013 The block SHALL have port SAMPLE_VALID  output  1  one-cycle pulse when X/Y/Z_DATA update.
REQ-014 The block SHALL have port READY  output  1  accelerometer setup completed.
REQ-015 The block SHALL have port ERROR  output  1  sticky transaction-timeout flag.

Function
REQ-016 The FSM SHALL have states SETUP_ISSUE, SETUP_WAIT, IDLE, ISSUE, WAIT_DONE, PUBLISH, FAULT.
REQ-017 Out of reset, the FSM SHALL enter SETUP_ISSUE with SPI_OP=1000, regardless of ENABLE.
REQ-018 In SETUP_ISSUE and ISSUE, SPI_START SHALL pulse for exactly one cycle on the first cycle with SPI_BUSY=0, followed by a move to SETUP_WAIT or WAIT_DONE; while SPI_BUSY=1, the FSM SHALL hold without pulsing.
REQ-019 SPI_OP SHALL remain stable from the ISSUE cycle until SPI_DONE is accepted, and SHALL be 0000 in IDLE, PUBLISH and FAULT.
REQ-020 On SPI_DONE in SETUP_WAIT: READY<=1 on the next edge; FSM->IDLE.
REQ-021 The period counter SHALL run 0..SAMPLE_PERIOD-1 only while READY=1 and ENABLE=1, and SHALL clear to 0 when either is low; a tick SHALL occur on the wrap to 0.
REQ-022 A tick SHALL set a one-deep PENDING flag; any further tick while PENDING=1 SHALL be dropped.
REQ-023 In IDLE with PENDING=1 and ENABLE=1: FSM->ISSUE with SPI_OP=0001 and PENDING cleared; if ENABLE=0, PENDING SHALL be cleared and FSM SHALL stay in IDLE.
REQ-024 In WAIT_DONE on SPI_DONE: SPI_RDATA SHALL be captured into an internal holding register for the current axis; next state is ISSUE with SPI_OP 0010 after X and 0100 after Y, or PUBLISH after Z.
REQ-025 In PUBLISH, X/Y/Z_DATA SHALL be loaded together from the holding registers, SAMPLE_VALID SHALL pulse for one cycle, and FSM->IDLE; outputs SHALL never expose a partial set.
REQ-026 Latency: SAMPLE_VALID SHALL be high exactly 2 cycles after the cycle in which the Z SPI_DONE is sampled.
REQ-027 Deasserting ENABLE mid-set SHALL NOT abort the set; the set SHALL complete and publish.
REQ-028 SPI_DONE outside SETUP_WAIT/WAIT_DONE SHALL be ignored.
REQ-029 The timeout counter SHALL clear on entry to SETUP_WAIT/WAIT_DONE; reaching TIMEOUT without SPI_DONE SHALL cause FAULT: ERROR<=1, READY<=0, holding registers unchanged.
REQ-030 SPI_DONE and timeout in the same cycle SHALL resolve as SPI_DONE (no fault).
REQ-031 In FAULT, CLEAR_ERROR SHALL clear ERROR and PENDING and send FSM->SETUP_ISSUE (full re-setup); X/Y/Z_DATA SHALL keep their last published values.

Reset
REQ-032 RESET SHALL asynchronously force: FSM=SETUP_ISSUE, SPI_OP=0000, SPI_START=0, X/Y/Z_DATA=0, SAMPLE_VALID=0, READY=0, ERROR=0, PENDING=0, all counters 0; SPI_OP SHALL become 1000 on the first edge after release.
REQ-033 RESET mid-transaction SHALL abandon it without pulsing SAMPLE_VALID.

Verification (SAMPLE_PERIOD=100, TIMEOUT=50; engine model: BUSY 10 cycles, DONE 1 cycle)
REQ-034 Reset release, ENABLE=0 -> one START with OP=1000, READY=1 after DONE, no further STARTs for 1000 cycles.
REQ-035 ENABLE=1, engine returns 0x11/0x22/0x33 -> START sequence OP=0001/0010/0100, SAMPLE_VALID pulse with X=0x11 Y=0x22 Z=0x33, repeat every 100 cycles.
REQ-036 SPI_BUSY held high 5 extra cycles before X issue -> START delayed until BUSY=0, single pulse only.
REQ-037 Withhold DONE on Y read -> ERROR=1 and READY=0 at cycle 50 of WAIT_DONE, X/Y/Z_DATA unchanged; CLEAR_ERROR -> OP=1000 re-issued.
REQ-038 ENABLE dropped during Y read -> Z still read, SAMPLE_VALID pulses once, then IDLE with no further STARTs.
REQ-039 RESET asserted during Z WAIT_DONE -> outputs at reset values immediately, no SAMPLE_VALID, setup re-issued after release.
